// File: rtl/traffic_conflict_monitor.sv
// Purpose: safety gate between the traffic-light FSM and the lamp drivers; blocks illegal lamp vectors and flashes red on fault.
// Latency: 2 cycles from *_in to *_out in PASS. A faulty vector is never forwarded.
// Backpressure: none. The inputs are sampled every cycle, and clr_fault is the only way to leave FAULT (apart from reset).
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW = 8,
    parameter int MAX_PHASE  = 16,
    parameter int FLASH_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] n_in,
    input  logic [2:0] s_in,
    input  logic [2:0] w_in,
    input  logic [2:0] e_in,
    input  logic       clr_fault,
    output logic [2:0] n_out,
    output logic [2:0] s_out,
    output logic [2:0] w_out,
    output logic [2:0] e_out,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int HW = $clog2(MAX_PHASE + 2);
    localparam int FW = $clog2(FLASH_DIV) + 1;

    localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_PHASE + 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0] MIN_Y      = HW'(MIN_YELLOW);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    localparam logic [2:0]  GRN     = 3'b001;
    localparam logic [2:0]  YEL     = 3'b010;
    localparam logic [2:0]  RED     = 3'b100;
    localparam logic [11:0] ALL_RED = {4{RED}};
    localparam logic [11:0] ALL_OFF = 12'h000;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        PASS  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t        state, state_nxt;

    // Lamp vectors are packed as {n, s, w, e}. Direction 3 is north.
    logic [11:0]   in_q;
    logic [11:0]   prev_q, prev_nxt;
    logic [11:0]   out_q, out_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt, hold_upd;
    logic [FW-1:0] flash_cnt, flash_cnt_nxt;
    logic          flash_on, flash_on_nxt;
    logic [2:0]    code_q, code_nxt;

    logic [2:0]    cur_d, prv_d;
    logic [2:0]    nonred_cnt;
    logic          illegal, conflict, bad_seq, short_y, wdog;
    logic [2:0]    det_code;

    // Input register stage: a copy of the FSM lamp codes, taken every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_q <= ALL_RED;
        else      in_q <= {n_in, s_in, w_in, e_in};
    end

    // Hold counter for the vector now in in_q. It saturates so that the watchdog compare stays stable.
    always_comb begin
        if (in_q != prev_q)        hold_nxt = HOLD_ONE;
        else if (hold_cnt == HOLD_MAX) hold_nxt = HOLD_MAX;
        else                       hold_nxt = hold_cnt + HOLD_ONE;
    end

    // Per-direction legality, conflict, sequence and short-yellow checks of in_q against prev_q.
    always_comb begin
        illegal    = 1'b0;
        bad_seq    = 1'b0;
        short_y    = 1'b0;
        nonred_cnt = 3'd0;
        cur_d      = RED;
        prv_d      = RED;
        for (int d = 0; d < 4; d++) begin
            cur_d = in_q[d*3 +: 3];
            prv_d = prev_q[d*3 +: 3];
            if (!(cur_d == GRN || cur_d == YEL || cur_d == RED))
                illegal = 1'b1;
            if (cur_d != RED)
                nonred_cnt = nonred_cnt + 3'd1;
            if (cur_d != prv_d &&
                !((prv_d == GRN && cur_d == YEL) ||
                  (prv_d == YEL && cur_d == RED) ||
                  (prv_d == RED && cur_d == GRN)))
                bad_seq = 1'b1;
            // hold_cnt still belongs to the yellow vector on the cycle it turns red.
            if (prv_d == YEL && cur_d == RED && hold_cnt < MIN_Y)
                short_y = 1'b1;
        end
        conflict = (nonred_cnt > 3'd1);
        wdog     = (hold_nxt == HOLD_MAX);
    end

    // When several faults occur together, the lowest fault code is reported.
    always_comb begin
        det_code = 3'd0;
        if (illegal)       det_code = 3'd1;
        else if (conflict) det_code = 3'd2;
        else if (bad_seq)  det_code = 3'd3;
        else if (short_y)  det_code = 3'd4;
        else if (wdog)     det_code = 3'd5;
    end

    // Next-state and next-output logic for INIT / PASS / FAULT.
    always_comb begin
        state_nxt     = state;
        out_nxt       = out_q;
        code_nxt      = code_q;
        flash_cnt_nxt = flash_cnt;
        flash_on_nxt  = flash_on;
        prev_nxt      = in_q;
        hold_upd      = hold_nxt;
        case (state)
            INIT: begin
                out_nxt = ALL_RED;
                // The first legal vector seeds the sequence history. No sequence check is applied to it.
                if (!illegal && !conflict)
                    state_nxt = PASS;
            end
            PASS: begin
                if (det_code != 3'd0) begin
                    state_nxt     = FAULT;
                    code_nxt      = det_code;
                    out_nxt       = ALL_RED;
                    flash_cnt_nxt = '0;
                    flash_on_nxt  = 1'b1;
                end else begin
                    out_nxt = in_q;
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_nxt = INIT;
                    code_nxt  = 3'd0;
                    out_nxt   = ALL_RED;
                    prev_nxt  = ALL_RED;
                    hold_upd  = '0;
                end else begin
                    if (flash_cnt == FLASH_LAST) begin
                        flash_cnt_nxt = '0;
                        flash_on_nxt  = ~flash_on;
                    end else begin
                        flash_cnt_nxt = flash_cnt + FW'(1);
                    end
                    out_nxt = flash_on_nxt ? ALL_RED : ALL_OFF;
                end
            end
            default: begin
                state_nxt = INIT;
                out_nxt   = ALL_RED;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    // Datapath registers: history, hold counter, lamp outputs, fault code and flasher.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= ALL_RED;
            hold_cnt  <= '0;
            out_q     <= ALL_RED;
            code_q    <= 3'd0;
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end else begin
            prev_q    <= prev_nxt;
            hold_cnt  <= hold_upd;
            out_q     <= out_nxt;
            code_q    <= code_nxt;
            flash_cnt <= flash_cnt_nxt;
            flash_on  <= flash_on_nxt;
        end
    end

    assign {n_out, s_out, w_out, e_out} = out_q;
    assign fault      = (state == FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Purpose: directed bench for traffic_conflict_monitor. Each scenario is checked against hand-computed lamp and fault values.
// Latency: applies one vector per clock and samples 1 time unit after the rising edge.
// Backpressure: none. A time limit stops a stuck run.
module tb_traffic_conflict_monitor;

    localparam logic [11:0] AR = 12'b100_100_100_100;
    localparam logic [11:0] NG = 12'b001_100_100_100;
    localparam logic [11:0] NY = 12'b010_100_100_100;
    localparam logic [11:0] NS_CONFLICT = 12'b001_001_100_100;
    localparam logic [11:0] N_BAD = 12'b011_100_100_100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] n_in, s_in, w_in, e_in;
    logic       clr_fault = 1'b0;
    logic [2:0] n_out, s_out, w_out, e_out;
    logic       fault;
    logic [2:0] fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .n_in       (n_in),
        .s_in       (s_in),
        .w_in       (w_in),
        .e_in       (e_in),
        .clr_fault  (clr_fault),
        .n_out      (n_out),
        .s_out      (s_out),
        .w_out      (w_out),
        .e_out      (e_out),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log any mismatch.
    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] outs();
        return {n_out, s_out, w_out, e_out};
    endfunction

    // FSM pattern: NG, NY, SG, SY, WG, WY, EG, EY, each held for 8 cycles.
    function automatic logic [11:0] pat(input int c);
        logic [11:0] v;
        int ph;
        int dir;
        ph  = (c / 8) % 8;
        dir = ph / 2;
        v   = AR;
        v[(3 - dir) * 3 +: 3] = (ph % 2 == 1) ? 3'b010 : 3'b001;
        return v;
    endfunction

    task automatic step(input logic [11:0] v);
        {n_in, s_in, w_in, e_in} = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset();
        clr_fault = 1'b0;
        {n_in, s_in, w_in, e_in} = AR;
        @(negedge clk);
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset values, then the normal pattern with 2-cycle latency; clr_fault in PASS is ignored.
        do_reset();
        chk("rst_out", outs(), AR);
        chk("rst_fault", 12'(fault), 12'd0);
        chk("rst_code", 12'(fault_code), 12'd0);
        for (int c = 0; c < 200; c++) begin
            clr_fault = (c == 100);
            step(pat(c));
            chk("t1_out", outs(), (c == 0) ? AR : pat(c - 1));
            chk("t1_fault", 12'(fault), 12'd0);
        end
        clr_fault = 1'b0;

        // 2: conflicting greens, followed by the flash pattern.
        do_reset();
        run(NG, 4);
        step(NS_CONFLICT);
        chk("t2_pre_fault", 12'(fault), 12'd0);
        chk("t2_pre_out", outs(), NG);
        for (int k = 1; k <= 12; k++) begin
            step(NG);
            chk("t2_fault", 12'(fault), 12'd1);
            chk("t2_code", 12'(fault_code), 12'd2);
            chk("t2_flash", outs(), ((k >= 5) && (k <= 8)) ? 12'h000 : AR);
        end

        // 6a: clr_fault returns the block to INIT, and it then re-enters PASS.
        clr_fault = 1'b1;
        step(NG);
        clr_fault = 1'b0;
        chk("t6_clr_fault", 12'(fault), 12'd0);
        chk("t6_clr_code", 12'(fault_code), 12'd0);
        chk("t6_clr_out", outs(), AR);
        step(NG);
        chk("t6_init_out", outs(), AR);
        step(NG);
        chk("t6_pass_out", outs(), NG);
        chk("t6_pass_fault", 12'(fault), 12'd0);

        // 6b: async reset in the off half of the flash cycle.
        step(NS_CONFLICT);
        step(NG);
        chk("t6_refault", 12'(fault_code), 12'd2);
        run(NG, 4);
        chk("t6_off", outs(), 12'h000);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_out", outs(), AR);
        chk("t6_rst_fault", 12'(fault), 12'd0);
        chk("t6_rst_code", 12'(fault_code), 12'd0);
        @(negedge clk);
        rst = 1'b1;

        // 3a: green goes directly to red.
        do_reset();
        run(NG, 8);
        step(AR);
        chk("t3_pre", 12'(fault), 12'd0);
        step(AR);
        chk("t3_fault", 12'(fault), 12'd1);
        chk("t3_code", 12'(fault_code), 12'd3);
        chk("t3_out", outs(), AR);

        // 3b: illegal encoding; code 1 has priority over the sequence fault.
        do_reset();
        run(NG, 2);
        step(N_BAD);
        chk("t3b_pre", 12'(fault), 12'd0);
        step(NG);
        chk("t3b_code", 12'(fault_code), 12'd1);
        chk("t3b_out", outs(), AR);

        // 4a: yellow held 5 cycles.
        do_reset();
        run(NG, 4);
        run(NY, 5);
        step(AR);
        chk("t4_y5_pre", 12'(fault), 12'd0);
        step(AR);
        chk("t4_y5_code", 12'(fault_code), 12'd4);

        // 4c: yellow held 7 cycles, one short of the minimum.
        do_reset();
        run(NG, 4);
        run(NY, 7);
        run(AR, 2);
        chk("t4_y7_code", 12'(fault_code), 12'd4);

        // 4b: yellow held exactly 8 cycles is legal.
        do_reset();
        run(NG, 4);
        run(NY, 8);
        run(AR, 3);
        chk("t4_y8_fault", 12'(fault), 12'd0);
        chk("t4_y8_out", outs(), AR);

        // 5a: watchdog fires on the 17th held cycle.
        do_reset();
        run(NG, 17);
        chk("t5_16_fault", 12'(fault), 12'd0);
        chk("t5_16_out", outs(), NG);
        step(NG);
        chk("t5_17_fault", 12'(fault), 12'd1);
        chk("t5_17_code", 12'(fault_code), 12'd5);

        // 5b: 16 held cycles followed by a legal change.
        do_reset();
        run(NG, 16);
        run(NY, 3);
        chk("t5b_fault", 12'(fault), 12'd0);
        chk("t5b_out", outs(), NY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
